// File: rtl/keypad_scanner_pkg.sv
// Shared types, key codes and decode helpers for the 4x4 keypad scanner.
package keypad_scanner_pkg;

   typedef enum logic [1:0] {
      ST_SCAN        = 2'd0,
      ST_DEB_PRESS   = 2'd1,
      ST_PRESSED     = 2'd2,
      ST_DEB_RELEASE = 2'd3
   } state_t;

   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_HASH = 4'd11;
   localparam logic [3:0] KEY_A    = 4'd12;
   localparam logic [3:0] KEY_B    = 4'd13;
   localparam logic [3:0] KEY_C    = 4'd14;
   localparam logic [3:0] KEY_D    = 4'd15;

   // Board layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
   function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'h0:    code = 4'd1;
         4'h1:    code = 4'd2;
         4'h2:    code = 4'd3;
         4'h3:    code = KEY_A;
         4'h4:    code = 4'd4;
         4'h5:    code = 4'd5;
         4'h6:    code = 4'd6;
         4'h7:    code = KEY_B;
         4'h8:    code = 4'd7;
         4'h9:    code = 4'd8;
         4'hA:    code = 4'd9;
         4'hB:    code = KEY_C;
         4'hC:    code = KEY_STAR;
         4'hD:    code = 4'd0;
         4'hE:    code = KEY_HASH;
         default: code = KEY_D;
      endcase
      return code;
   endfunction

   function automatic logic [9:0] digit_mask(input logic [3:0] code);
      return (code < 4'd10) ? (10'd1 << code) : 10'd0;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the lock-facing key outputs of keypad_scanner.
interface keypad_scanner_if;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [9:0] pwds;
   logic       backspace;
   logic       confirm;
   logic       operate;
   logic       administrate;
   logic       relieve;
   logic       key_valid;
   logic [3:0] key_code;

   modport master (
      input  row_n,
      output col_n, pwds, backspace, confirm, operate, administrate, relieve,
             key_valid, key_code
   );

   modport slave (
      output row_n,
      input  col_n, pwds, backspace, confirm, operate, administrate, relieve,
             key_valid, key_code
   );
endinterface

// File: rtl/keypad_scanner_tick_gen.sv
// Scan tick divider: one-clock tick every CLK_HZ/SCAN_HZ clocks.
module keypad_scanner_tick_gen #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int SCAN_HZ = 1000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);
   localparam int DIV   = CLK_HZ / SCAN_HZ;
   localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] RELOAD = DIV_W'(DIV - 1);

   logic [DIV_W-1:0] div_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= RELOAD;
         tick    <= 1'b0;
      end else begin
         tick    <= (div_cnt == '0);
         div_cnt <= (div_cnt == '0) ? RELOAD : div_cnt - 1'b1;
      end
   end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, tick-based debounce FSM and key decode for password_lock.
// Build macro KEYPAD_AUTOREPEAT_EN adds key_valid auto-repeat while a key is held.
//
// state          | meaning
// ST_SCAN        | rotating columns, waiting for exactly one row low
// ST_DEB_PRESS   | column frozen, counting stable ticks of the latched row
// ST_PRESSED     | key accepted and held output asserted
// ST_DEB_RELEASE | latched row high, counting stable ticks before clearing
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int CLK_HZ         = 100_000_000,
   parameter int SCAN_HZ        = 1000,
   parameter int DEBOUNCE_SCANS = 20
`ifdef KEYPAD_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY   = 500,
   parameter int REPEAT_PERIOD  = 100
`endif
) (
   input  logic             clk_100Mhz,
   input  logic             reset,
   keypad_scanner_if.master kp
);
   localparam int CNT_W = ($clog2(DEBOUNCE_SCANS + 1) > 5) ? $clog2(DEBOUNCE_SCANS + 1) : 5;
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             tick;
   logic [3:0]       row_meta, row_sync, rows_low;
   logic             single_low;
   logic [1:0]       row_idx;
   state_t           state, state_nxt;
   logic [1:0]       col, col_nxt;
   logic [1:0]       row_lat, row_lat_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic [3:0]       code, code_nxt;
   logic             held, held_nxt;
   logic             valid, valid_nxt;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;
   localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);
   logic [REP_W-1:0] rep_cnt, rep_nxt;
`endif

   keypad_scanner_tick_gen #(
      .CLK_HZ  (CLK_HZ),
      .SCAN_HZ (SCAN_HZ)
   ) u_tick (
      .clk   (clk_100Mhz),
      .rst_n (reset),
      .tick  (tick)
   );

   always_ff @(posedge clk_100Mhz or negedge reset) begin
      if (!reset) begin
         row_meta <= 4'hF;
         row_sync <= 4'hF;
      end else begin
         row_meta <= kp.row_n;
         row_sync <= row_meta;
      end
   end

   assign rows_low   = ~row_sync;
   assign single_low = (rows_low != 4'd0) && ((rows_low & (rows_low - 4'd1)) == 4'd0);
   assign cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;

   always_comb begin
      case (rows_low)
         4'b0010: row_idx = 2'd1;
         4'b0100: row_idx = 2'd2;
         4'b1000: row_idx = 2'd3;
         default: row_idx = 2'd0;
      endcase
   end

   always_comb begin
      state_nxt   = state;
      col_nxt     = col;
      row_lat_nxt = row_lat;
      cnt_nxt     = cnt;
      code_nxt    = code;
      held_nxt    = held;
      valid_nxt   = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_nxt     = rep_cnt;
`endif
      if (tick) begin
         case (state)
            ST_SCAN: begin
               if (single_low) begin
                  row_lat_nxt = row_idx;
                  cnt_nxt     = CNT_ONE;
                  state_nxt   = ST_DEB_PRESS;
               end else begin
                  col_nxt = col + 2'd1;
               end
            end
            ST_DEB_PRESS: begin
               if (single_low && (row_idx == row_lat)) begin
                  cnt_nxt = cnt_inc;
                  if (cnt_inc >= CNT_DONE) begin
                     valid_nxt = 1'b1;
                     code_nxt  = key_lookup(row_lat, col);
                     held_nxt  = 1'b1;
                     state_nxt = ST_PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
                     rep_nxt   = REP_FIRST;
`endif
                  end
               end else begin
                  cnt_nxt   = '0;
                  state_nxt = ST_SCAN;
                  col_nxt   = col + 2'd1;
               end
            end
            ST_PRESSED: begin
               // Only the latched row matters here; other rows dropping are ignored.
               if (row_sync[row_lat]) begin
                  cnt_nxt   = CNT_ONE;
                  state_nxt = ST_DEB_RELEASE;
               end
`ifdef KEYPAD_AUTOREPEAT_EN
               else if (rep_cnt == '0) begin
                  valid_nxt = 1'b1;
                  rep_nxt   = REP_NEXT;
               end else begin
                  rep_nxt = rep_cnt - 1'b1;
               end
`endif
            end
            ST_DEB_RELEASE: begin
               if (row_sync[row_lat]) begin
                  cnt_nxt = cnt_inc;
                  if (cnt_inc >= CNT_DONE) begin
                     held_nxt  = 1'b0;
                     cnt_nxt   = '0;
                     state_nxt = ST_SCAN;
                     col_nxt   = col + 2'd1;
                  end
               end else begin
                  cnt_nxt   = '0;
                  state_nxt = ST_PRESSED;
               end
            end
            default: state_nxt = ST_SCAN;
         endcase
      end
   end

   always_ff @(posedge clk_100Mhz or negedge reset) begin
      if (!reset) begin
         state   <= ST_SCAN;
         col     <= 2'd0;
         row_lat <= 2'd0;
         cnt     <= '0;
         code    <= 4'd0;
         held    <= 1'b0;
         valid   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_cnt <= '0;
`endif
      end else begin
         state   <= state_nxt;
         col     <= col_nxt;
         row_lat <= row_lat_nxt;
         cnt     <= cnt_nxt;
         code    <= code_nxt;
         held    <= held_nxt;
         valid   <= valid_nxt;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_cnt <= rep_nxt;
`endif
      end
   end

   assign kp.col_n        = ~(4'b0001 << col);
   assign kp.pwds         = held ? digit_mask(code) : 10'd0;
   assign kp.backspace    = held && (code == KEY_STAR);
   assign kp.confirm      = held && (code == KEY_HASH);
   assign kp.operate      = held && (code == KEY_A);
   assign kp.administrate = held && (code == KEY_B);
   assign kp.relieve      = held && (code == KEY_C);
   assign kp.key_valid    = valid;
   assign kp.key_code     = code;
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad matrix model, per-cycle output model, directed scenarios.
`timescale 1ns/1ps
module tb_keypad_scanner;
   localparam int TICK = 16;   // clocks per scan tick, i.e. per simulated millisecond
`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int EXP_HOLD_STROBES = 11;
`else
   localparam int EXP_HOLD_STROBES = 1;
`endif

   logic        clk;
   logic        rst_n;
   logic [15:0] pressed;     // bit r*4+c = key at row r, column c is physically closed
   logic [3:0]  row_model;
   logic [14:0] outs;
   logic [14:0] prev_outs;
   int          exp_key;
   int          strobes;
   int          falls;
   int          first_strobe_cyc;
   int          cyc;
   int          n_cmp;
   int          n_err;

   keypad_scanner_if kif ();

   keypad_scanner #(
      .CLK_HZ         (TICK * 1000),
      .SCAN_HZ        (1000),
      .DEBOUNCE_SCANS (20)
   ) dut (
      .clk_100Mhz (clk),
      .reset      (rst_n),
      .kp         (kif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Passive matrix: a row reads low when a closed key sits on the driven-low column.
   always_comb begin
      row_model = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !kif.col_n[c]) row_model[r] = 1'b0;
   end
   assign kif.row_n = row_model;

   // Held-output vector indexed by key code: bits 0-9 pwds, 10 '*', 11 '#', 12 'A', 13 'B', 14 'C'.
   function automatic logic [14:0] model_outs(input int code);
      logic [14:0] v;
      v = '0;
      if (code >= 0 && code < 15) v[code] = 1'b1;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input int val, input int lo, input int hi);
      n_cmp++;
      if (val < lo || val > hi) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
      end
   endtask

   always @(negedge clk) begin
      outs = {kif.relieve, kif.administrate, kif.operate, kif.confirm, kif.backspace, kif.pwds};
      if (rst_n) begin
         check("col_n_one_cold", $countones(~kif.col_n), 1);
         check("held_at_most_one", ($countones(outs) <= 1), 1);
         if (exp_key < 0) begin
            check("idle_outputs", outs, 0);
            check("idle_key_valid", kif.key_valid, 0);
         end else begin
            if (outs != 0) check("held_decode", outs, model_outs(exp_key));
            if (kif.key_valid) begin
               check("strobe_code", kif.key_code, exp_key);
               check("strobe_held", outs, model_outs(exp_key));
               check("strobe_while_pressed", (pressed != 16'd0), 1);
               if (strobes == 0) first_strobe_cyc = cyc;
               strobes++;
            end
         end
         if (prev_outs != 0 && outs == 0) falls++;
         prev_outs = outs;
      end else begin
         prev_outs = '0;
      end
   end

   task automatic wait_ms(input int n);
      repeat (n * TICK) @(negedge clk);
   endtask

   task automatic wait_until(input int c0, input int ms);
      while (cyc - c0 < ms * TICK) @(negedge clk);
   endtask

   // Bounded wait for the first strobe, then check press latency from contact.
   task automatic wait_strobe(input string name, input int c0);
      int n;
      n = 0;
      while (strobes == 0 && n < 30 * TICK) begin
         @(negedge clk);
         n++;
      end
      check({name, "_strobe_seen"}, (strobes > 0), 1);
      if (strobes > 0)
         check_range({name, "_latency"}, first_strobe_cyc - c0, 19 * TICK, 24 * TICK + 4);
   endtask

   task automatic start_key(input int idx, input int code, output int c0);
      exp_key = code;
      strobes = 0;
      falls   = 0;
      pressed = 16'd0;
      pressed[idx] = 1'b1;
      c0 = cyc;
   endtask

   initial begin
      int c0;
      int rel;
      logic [3:0] seen;
      n_cmp = 0;
      n_err = 0;
      cyc = 0;
      strobes = 0;
      falls = 0;
      first_strobe_cyc = 0;
      exp_key = -1;
      pressed = 16'd0;
      prev_outs = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;

      @(negedge clk);
      check("reset_col_n", kif.col_n, 4'b1110);
      check("reset_key_code", kif.key_code, 4'd0);
      check("reset_outs", {kif.relieve, kif.administrate, kif.operate, kif.confirm,
                           kif.backspace, kif.pwds}, 0);
      check("reset_key_valid", kif.key_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_ms(5);

      // '5' clean press for 50 ms, release timing
      start_key(5, 5, c0);
      wait_strobe("k5", c0);
      wait_until(c0, 40);
      check("k5_pwds", kif.pwds, 10'b0000100000);
      check("k5_code", kif.key_code, 4'd5);
      wait_until(c0, 50);
      pressed = 16'd0;
      rel = cyc;
      wait_until(rel, 18);
      check("k5_pwds_still_held", kif.pwds, 10'b0000100000);
      wait_until(rel, 21);
      check("k5_pwds_cleared", kif.pwds, 10'd0);
      check("k5_strobes", strobes, 1);
      wait_ms(10);

      // '1' with six 1 ms contact bounces, then stable
      start_key(0, 1, c0);
      for (int i = 0; i < 6; i++) begin
         pressed[0] = (i % 2 == 0);
         wait_ms(1);
      end
      pressed[0] = 1'b1;
      wait_ms(40);
      check("k1_pwds", kif.pwds, 10'b0000000010);
      check("k1_code", kif.key_code, 4'd1);
      pressed = 16'd0;
      wait_ms(30);
      check("k1_strobes", strobes, 1);

      // '2' and '5' together on one column: ghost, must be ignored
      exp_key = -1;
      strobes = 0;
      pressed = 16'd0;
      pressed[1] = 1'b1;
      pressed[5] = 1'b1;
      seen = 4'd0;
      for (int i = 0; i < 8; i++) begin
         seen = seen | ~kif.col_n;
         wait_ms(1);
      end
      check("ghost_col_rotates", seen, 4'hF);
      wait_ms(42);
      check("ghost_strobes", strobes, 0);
      pressed = 16'd0;
      wait_ms(5);

      // '#' held 30 ms, then bouncy release
      start_key(14, 11, c0);
      wait_ms(25);
      check("hash_confirm", kif.confirm, 1);
      check("hash_pwds", kif.pwds, 10'd0);
      check("hash_code", kif.key_code, 4'd11);
      wait_until(c0, 30);
      for (int i = 0; i < 5; i++) begin
         pressed[14] = (i % 2 == 1);
         wait_ms(1);
      end
      pressed = 16'd0;
      wait_ms(30);
      check("hash_confirm_cleared", kif.confirm, 0);
      check("hash_clear_count", falls, 1);
      check("hash_strobes", strobes, 1);

      // 'D': strobe with code 15, no held level
      start_key(15, 15, c0);
      wait_strobe("kd", c0);
      check("kd_code", kif.key_code, 4'd15);
      wait_until(c0, 30);
      pressed = 16'd0;
      wait_ms(30);
      check("kd_strobes", strobes, 1);

      // '0' held, reset pulsed while PRESSED
      start_key(13, 0, c0);
      wait_ms(30);
      check("k0_pwds", kif.pwds, 10'b0000000001);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_outs", {kif.relieve, kif.administrate, kif.operate, kif.confirm,
                             kif.backspace, kif.pwds}, 0);
      check("rst_mid_col_n", kif.col_n, 4'b1110);
      check("rst_mid_key_valid", kif.key_valid, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      strobes = 0;
      c0 = cyc;
      wait_strobe("k0_rereport", c0);
      wait_until(c0, 40);
      check("k0_pwds_again", kif.pwds, 10'b0000000001);
      pressed = 16'd0;
      wait_ms(30);
      check("k0_strobes", strobes, 1);

      // '3' held 1.5 s: auto-repeat count depends on the build
      start_key(2, 3, c0);
      wait_ms(1500);
      check("k3_pwds", kif.pwds, 10'b0000001000);
      pressed = 16'd0;
      wait_ms(30);
      check("k3_hold_strobes", strobes, EXP_HOLD_STROBES);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
